unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Sequences and shares a single-port unified instruction/data memory between two requesters: the fetch stage (IF) and the load/store path (D).
- The load/store path is driven by the MemRead/MemWrite decode outputs.
- Sits between the core datapath and the memory macro.
- Runs one transaction at a time under a fixed-latency FSM.
- Honours the core's endProgram halt so that no new access is issued after ECALL/EBREAK.

Parameters:
- ADDR_W, 12: byte-address width of both requesters and the memory.
- MEM_LAT, 2: memory read latency in cycles after mem_en, legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held stable until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction word.
- d_req  in  1  data request (MemRead|MemWrite); held stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete.
- d_rdata  out  32  load data; 0 for stores.
- halt  in  1  endProgram from the control unit.
- mem_en  out  1  memory access strobe, exactly one cycle.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables; 4'hF for reads.
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
- halted  out  1  arbiter is in HALT.

Behaviour:
- Reset: all outputs 0 and state IDLE. Reset is asynchronous; any in-flight transaction is dropped with no rvalid.
- FSM states: IDLE, BUSY_IF, BUSY_D, HALT.
- Grant in IDLE (combinational, cycle T): if halt → no grant; next state HALT. Else if d_req → d_gnt=1; next BUSY_D. Else if if_req → if_gnt=1; next BUSY_IF. Data beats fetch because it belongs to the older instruction.
- Grants are only issued in IDLE; if_gnt and d_gnt are never both 1.
- Issue: mem_en/mem_we/mem_be/mem_addr/mem_wdata are registered at the end of T. mem_en=1 in T+1 only; the other mem_* outputs hold their values until the next issue.
- Counter: loads MEM_LAT at T+1 and decrements each cycle. At 0 (cycle T+1+MEM_LAT), mem_rdata is captured into the rdata register and rvalid pulses for the owner. State returns to IDLE in that same cycle, so a new grant is possible in it.
- Throughput: one transaction per MEM_LAT+1 cycles.
- Stores: same timing. d_rvalid acts as the write-ack; d_rdata=0.
- halt during BUSY_*: the transaction completes with its rvalid, then the FSM goes to HALT.
- HALT: no grants, mem_en=0, halted=1, rdata holds. Exit only via rst_n.
- if_rdata and d_rdata hold their last value between pulses.
- Counter width: $clog2(MEM_LAT+1); no wrap occurs because it is reloaded at every issue.
- Misaligned address: bits [1:0] are dropped on mem_addr; the block does not check alignment.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_if_stall[31:0] and perf_d_stall[31:0]. Each counts cycles with req=1 and gnt=0, excluding HALT. Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist. Timing is identical either way.

Decomposition:
- defines.v gets: the state encodings (ARB_IDLE=2'd0, ARB_BUSY_IF=2'd1, ARB_BUSY_D=2'd2, ARB_HALT=2'd3) and the mem_be read value 4'hF.
- One natural sub-module: arb_lat_counter. It is a loadable down-counter with a done flag, parameterised by MEM_LAT.

Test Plan (MEM_LAT=2):
- Fetch only: reset, then if_req=1, if_addr=12'h010 at T. Expect: if_gnt at T; mem_en=1 with mem_addr=12'h010 at T+1; mem_rdata=32'h00500093 gives if_rvalid=1, if_rdata=32'h00500093 at T+3.
- Contention: if_req=1 and d_req=1 (load, d_addr=12'h104) both at T. Expect: d_gnt at T; if_gnt at T+3; d_rvalid at T+3; if_rvalid at T+6.
- Store: d_we=1, d_be=4'b0011, d_wdata=32'hDEADBEEF, d_addr=12'h0FE. Expect: mem_we=1, mem_addr=12'h0FC, mem_be=4'b0011 at T+1; d_rvalid=1, d_rdata=0 at T+3.
- Halt in flight: halt=1 at T+1 of a fetch. Expect: if_rvalid still at T+3; halted=1 from T+4; if_req held high gives no further if_gnt or mem_en for 20 cycles.
- Reset mid-op: rst_n=0 at T+2. Expect: all outputs 0 immediately and no rvalid. After release, fetch at 12'h000 is granted normally.
- ARB_PERF_CNT_EN: repeat the contention scenario. Expect perf_if_stall=3, perf_d_stall=0.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2,
        ARB_HALT    = 2'd3
    } arb_state_e;

    localparam logic [3:0] MEM_BE_READ = 4'hF;

endpackage

// File: rtl/unified_mem_arbiter_lat_counter.sv
// Loadable down-counter that flags the cycle in which the memory read data is valid.
module arb_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(MEM_LAT);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (D) with fixed-latency sequencing.
// Optional stall counters are built when ARB_PERF_CNT_EN is defined.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              halted
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    arb_state_e  state_q, state_d;
    logic        halt_pend_q;
    logic        busy;
    logic        cnt_done;
    logic        arb_open;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (if_gnt | d_gnt),
        .done  (cnt_done)
    );

    assign busy = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_D);

    // The completion cycle behaves like IDLE so back-to-back grants need no bubble;
    // rst_n gates it so grants stay low while reset is asserted.
    assign arb_open = rst_n && ((state_q == ARB_IDLE) || (busy && cnt_done));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        if (arb_open) begin
            if (halt || halt_pend_q) begin
                state_d = ARB_HALT;
            end else if (d_req) begin
                d_gnt   = 1'b1;
                state_d = ARB_BUSY_D;
            end else if (if_req) begin
                if_gnt  = 1'b1;
                state_d = ARB_BUSY_IF;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            halt_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // A halt seen mid-transaction is remembered even if endProgram drops again.
            if (busy && halt) begin
                halt_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= if_gnt | d_gnt;
            if (d_gnt) begin
                mem_we    <= d_we;
                mem_be    <= d_we ? d_be : MEM_BE_READ;
                mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= d_wdata;
            end else if (if_gnt) begin
                mem_we   <= 1'b0;
                mem_be   <= MEM_BE_READ;
                mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
            end
        end
    end

    assign if_rvalid = (state_q == ARB_BUSY_IF) && cnt_done;
    assign d_rvalid  = (state_q == ARB_BUSY_D) && cnt_done;
    assign halted    = (state_q == ARB_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_we ? 32'h0 : mem_rdata;
            end
        end
    end

    // Read data is forwarded in its valid cycle, then held from the capture register.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid ? (mem_we ? 32'h0 : mem_rdata) : d_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic if_stall;
    logic d_stall;

    assign if_stall = if_req && !if_gnt && (state_q != ARB_HALT);
    assign d_stall  = d_req && !d_gnt && (state_q != ARB_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
        end else begin
            if (if_stall && (perf_if_stall != '1)) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
            if (d_stall && (perf_d_stall != '1)) begin
                perf_d_stall <= perf_d_stall + 32'd1;
            end
        end
    end
`else
    // Stall counters are not present in this build.
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter (MEM_LAT=2) with a latency-accurate memory model.
module tb_unified_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req, d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt, d_rvalid;
    logic [31:0]       d_rdata;
    logic              halt;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              halted;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       perf_if_stall, perf_d_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] if_exp_q[$];
    logic [31:0] d_exp_q[$];

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .halt      (halt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .halted    (halted)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_d_stall  (perf_d_stall)
`endif
    );

    function automatic logic [31:0] mem_model(input logic [ADDR_W-1:0] a);
        case (a)
            12'h010: return 32'h00500093;
            12'h104: return 32'hCAFEF00D;
            12'h000: return 32'h00000013;
            default: return {20'hA5A5A, a};
        endcase
    endfunction

    // Memory data is presented only in cycle T+1+LAT of an access issued in T+1.
    logic [LAT-1:0]    pipe_v;
    logic [ADDR_W-1:0] pipe_a [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[LAT-2:0], mem_en};
            pipe_a[0] <= mem_addr;
            for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign mem_rdata = pipe_v[LAT-1] ? mem_model(pipe_a[LAT-1]) : 32'hBAD0BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rvalid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && if_rvalid) begin
            if (if_exp_q.size() == 0) check("if_unexpected_rvalid", {31'd0, if_rvalid}, 32'd0);
            else check("if_rdata_sb", if_rdata, if_exp_q.pop_front());
        end
        if (rst_n && d_rvalid) begin
            if (d_exp_q.size() == 0) check("d_unexpected_rvalid", {31'd0, d_rvalid}, 32'd0);
            else check("d_rdata_sb", d_rdata, d_exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; halt = 1'b0;
        tick(); tick();
        check("rst_outputs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, halted}, 32'd0);
        check("rst_mem_addr_be", {mem_be, mem_addr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch only
        tick(); if_req = 1'b1; if_addr = 12'h010; if_exp_q.push_back(32'h00500093); #1;
        check("f_gnt_T", {if_gnt, d_gnt}, 32'b10);
        tick(); if_req = 1'b0; #1;
        check("f_mem_en_T1", {mem_en, mem_we}, 32'b10);
        check("f_mem_addr_T1", mem_addr, 32'h010);
        check("f_mem_be_T1", mem_be, 32'hF);
        tick(); check("f_no_rvalid_T2", {mem_en, if_rvalid}, 32'd0);
        tick(); check("f_rvalid_T3", if_rvalid, 32'd1);
        check("f_rdata_T3", if_rdata, 32'h00500093);
        tick(); check("f_rvalid_low_T4", if_rvalid, 32'd0);
        check("f_rdata_hold_T4", if_rdata, 32'h00500093);

        // Contention: data beats fetch
        tick(); if_req = 1'b1; if_addr = 12'h000; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h104;
        d_exp_q.push_back(32'hCAFEF00D); if_exp_q.push_back(32'h00000013); #1;
        check("c_gnt_T", {if_gnt, d_gnt}, 32'b01);
        tick(); d_req = 1'b0; #1;
        check("c_mem_addr_T1", mem_addr, 32'h104);
        check("c_if_gnt_T1", if_gnt, 32'd0);
        tick(); check("c_if_gnt_T2", if_gnt, 32'd0);
        tick(); check("c_d_rvalid_T3", d_rvalid, 32'd1);
        check("c_if_gnt_T3", {if_gnt, d_gnt}, 32'b10);
        tick(); if_req = 1'b0; #1;
        check("c_mem_T4", {mem_en, 19'd0, mem_addr}, {1'b1, 31'h000});
        tick(); check("c_if_rvalid_T5", if_rvalid, 32'd0);
        tick(); check("c_if_rvalid_T6", if_rvalid, 32'd1);
        check("c_d_rdata_hold", d_rdata, 32'hCAFEF00D);
`ifdef ARB_PERF_CNT_EN
        check("c_perf_if_stall", perf_if_stall, 32'd3);
        check("c_perf_d_stall", perf_d_stall, 32'd0);
`endif

        // Store
        tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 12'h0FE;
        d_exp_q.push_back(32'h0); #1;
        check("s_gnt_T", {if_gnt, d_gnt}, 32'b01);
        tick(); d_req = 1'b0; d_we = 1'b0; #1;
        check("s_mem_we_en_T1", {mem_en, mem_we}, 32'b11);
        check("s_mem_addr_T1", mem_addr, 32'h0FC);
        check("s_mem_be_T1", mem_be, 32'h3);
        check("s_mem_wdata_T1", mem_wdata, 32'hDEADBEEF);
        tick();
        tick(); check("s_d_rvalid_T3", d_rvalid, 32'd1);
        check("s_d_rdata_T3", d_rdata, 32'd0);
        tick(); check("s_d_hold_T4", {d_rvalid, d_rdata}, 33'd0);

        // Reset mid-operation
        tick(); if_req = 1'b1; if_addr = 12'h010; #1;
        check("r_gnt_T", if_gnt, 32'd1);
        tick(); if_req = 1'b0;
        tick(); rst_n = 1'b0; #1;
        check("r_outputs_zero", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, halted}, 32'd0);
        check("r_mem_zero", {mem_be, mem_addr}, 32'd0);
        check("r_if_rdata_zero", if_rdata, 32'd0);
        check("r_d_rdata_zero", d_rdata, 32'd0);
        tick(); check("r_no_rvalid_T3", {if_rvalid, d_rvalid}, 32'd0);
        tick(); rst_n = 1'b1;
        tick(); if_req = 1'b1; if_addr = 12'h000; if_exp_q.push_back(32'h00000013); #1;
        check("r_refetch_gnt", if_gnt, 32'd1);
        tick(); if_req = 1'b0; #1;
        check("r_refetch_mem", {mem_en, 19'd0, mem_addr}, {1'b1, 31'h000});
        tick();
        tick(); check("r_refetch_rvalid", if_rvalid, 32'd1);

        // Halt while a fetch is in flight
        tick(); if_req = 1'b1; if_addr = 12'h010; if_exp_q.push_back(32'h00500093); #1;
        check("h_gnt_T", if_gnt, 32'd1);
        tick(); halt = 1'b1;
        tick();
        tick(); check("h_rvalid_T3", {if_rvalid, if_gnt, halted}, 32'b100);
        tick(); check("h_halted_T4", halted, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("h_quiet", {if_gnt, d_gnt, mem_en, if_rvalid, halted}, 32'b00001);
            tick();
        end
`ifdef ARB_PERF_CNT_EN
        check("h_perf_if_stall", perf_if_stall, 32'd3);
`endif
        if_req = 1'b0;
        tick();

        check("if_queue_empty", if_exp_q.size(), 32'd0);
        check("d_queue_empty", d_exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
